// File: rtl/controle_vidas.sv
// controle_vidas: turns the wrapping 2-bit hit counters of every enemy ball into player lives.
// A new hit costs one life and opens an invulnerability window; reaching zero lives latches
// game over until a restart request.
//
// Ports:
//   CLOCK_50       system clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   pausa          1 = paused: invulnerability timer frozen, hits discarded
//   reiniciarJogo  level-sampled restart request (same effect as reset)
//   n_batidas_bus  ball i hit counter at [2i+1:2i], wraps 3->0
//   vidas          lives remaining
//   game_over      high while the game is over
//   invulneravel   high during the invulnerability window
//   dano           one-cycle pulse on each life loss
//   batidas_total  damaging hits since reset/restart, saturating at 255
module controle_vidas #(
    parameter int unsigned N_BOLAS        = 4,
    parameter int unsigned VIDAS_INICIAIS = 3,
    parameter int unsigned INVULN_CICLOS  = 50_000_000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   pausa,
    input  logic                   reiniciarJogo,
    input  logic [2*N_BOLAS-1:0]   n_batidas_bus,
    output logic [2:0]             vidas,
    output logic                   game_over,
    output logic                   invulneravel,
    output logic                   dano,
    output logic [7:0]             batidas_total
);

    localparam int unsigned HW = $clog2(3 * N_BOLAS + 1);
    localparam int unsigned TW = (INVULN_CICLOS > 1) ? $clog2(INVULN_CICLOS) : 1;

    typedef enum logic [1:0] {
        JOGANDO = 2'd0,
        INVULN  = 2'd1,
        FIM     = 2'd2
    } estado_t;

    estado_t              estado, estado_prox;
    logic [TW-1:0]        timer, timer_prox;
    logic [2*N_BOLAS-1:0] prev;
    logic [2:0]           vidas_prox;
    logic                 dano_prox;
    logic [7:0]           total_prox;
    logic [HW-1:0]        hits;
    logic [1:0]           delta;

    // Sum of per-ball counter advances since last cycle; 2-bit subtraction absorbs the wrap.
    always_comb begin
        hits  = '0;
        delta = '0;
        for (int i = 0; i < int'(N_BOLAS); i++) begin
            delta = n_batidas_bus[2*i +: 2] - prev[2*i +: 2];
            hits  = hits + HW'(delta);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        estado_prox = estado;
        timer_prox  = timer;
        vidas_prox  = vidas;
        dano_prox   = 1'b0;
        total_prox  = batidas_total;

        case (estado)
            JOGANDO: begin
                // Any number of simultaneous hits costs exactly one life.
                if (!pausa && hits != '0 && vidas != 3'd0) begin
                    vidas_prox = vidas - 3'd1;
                    dano_prox  = 1'b1;
                    if (batidas_total != 8'hFF) begin
                        total_prox = batidas_total + 8'd1;
                    end
                    if (vidas == 3'd1) begin
                        estado_prox = FIM;
                    end else begin
                        estado_prox = INVULN;
                        timer_prox  = TW'(INVULN_CICLOS - 1);
                    end
                end
            end
            INVULN: begin
                if (!pausa) begin
                    if (timer == '0) begin
                        estado_prox = JOGANDO;
                    end else begin
                        timer_prox = timer - TW'(1);
                    end
                end
            end
            FIM: begin
                vidas_prox = 3'd0;
            end
            default: begin
                estado_prox = JOGANDO;
            end
        endcase
    end

    // State and registered outputs; restart behaves exactly like reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset || reiniciarJogo) begin
            estado        <= JOGANDO;
            timer         <= '0;
            vidas         <= 3'(VIDAS_INICIAIS);
            dano          <= 1'b0;
            batidas_total <= 8'd0;
            game_over     <= 1'b0;
            invulneravel  <= 1'b0;
        end else begin
            estado        <= estado_prox;
            timer         <= timer_prox;
            vidas         <= vidas_prox;
            dano          <= dano_prox;
            batidas_total <= total_prox;
            game_over     <= (estado_prox == FIM);
            invulneravel  <= (estado_prox == INVULN);
        end
        // Counters are tracked every cycle so each advance is consumed exactly once.
        prev <= n_batidas_bus;
    end

endmodule
